debounce_multi: RTL and testbench



---
 rtl/debounce_multi.sv | 108 ++++++++++
 tb/tb_debounce_multi.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// N-channel debouncer: 2-flop synchroniser, stability counter and edge pulses per channel.
// Define DEBOUNCE_MULTI_EVT_EN to add sticky edge-event flags (evt_pend) and an irq output.
module debounce_multi #(
   parameter int unsigned       N_CH      = 22,
   parameter int unsigned       CNT_W     = 20,
   parameter int unsigned       DB_CYCLES = 500000,
   parameter logic [N_CH-1:0]   INV_MASK  = '0,
   parameter logic [N_CH-1:0]   RST_VAL   = '0
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [N_CH-1:0] raw_in,
   output logic [N_CH-1:0] db_out,
   output logic [N_CH-1:0] rise_pls,
   output logic [N_CH-1:0] fall_pls,
   input  logic [N_CH-1:0] evt_clr,
   output logic [N_CH-1:0] evt_pend,
   output logic            irq
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic [N_CH-1:0]  sync1_q, sync1_d;
   logic [N_CH-1:0]  sync2_q, sync2_d;
   logic [N_CH-1:0]  db_q, db_d;
   logic [N_CH-1:0]  rise_q, rise_d;
   logic [N_CH-1:0]  fall_q, fall_d;
   logic [CNT_W-1:0] cnt_q [N_CH];
   logic [CNT_W-1:0] cnt_d [N_CH];

   // Count consecutive cycles the synchronised input disagrees with the accepted level.
   always_comb begin
      sync1_d = raw_in ^ INV_MASK;
      sync2_d = sync1_q;
      db_d    = db_q;
      rise_d  = '0;
      fall_d  = '0;
      for (int i = 0; i < int'(N_CH); i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != db_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               db_d[i]   = sync2_q[i];
               rise_d[i] = sync2_q[i];
               fall_d[i] = ~sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1_q <= RST_VAL;
         sync2_q <= RST_VAL;
         db_q    <= RST_VAL;
         rise_q  <= '0;
         fall_q  <= '0;
         for (int i = 0; i < int'(N_CH); i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         db_q    <= db_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         for (int i = 0; i < int'(N_CH); i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign db_out   = db_q;
   assign rise_pls = rise_q;
   assign fall_pls = fall_q;

`ifdef DEBOUNCE_MULTI_EVT_EN
   logic [N_CH-1:0] evt_pend_q, evt_pend_d;
   logic            irq_q, irq_d;

   // Pulses visible this cycle set the flag, so a set beats a same-cycle clear.
   always_comb begin
      evt_pend_d = (evt_pend_q & ~evt_clr) | rise_q | fall_q;
      irq_d      = |evt_pend_d;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         evt_pend_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         evt_pend_q <= evt_pend_d;
         irq_q      <= irq_d;
      end
   end

   assign evt_pend = evt_pend_q;
   assign irq      = irq_q;
`else
   logic unused_evt_clr;

   assign unused_evt_clr = ^evt_clr;
   assign evt_pend       = '0;
   assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: vector table, directed corner sequences and random traffic vs a window model.
module tb_debounce_multi;

   localparam int unsigned DB   = 8;
   localparam int unsigned MAXE = 4096;
   localparam logic [3:0]  INV  = 4'b1000;
   localparam logic [3:0]  RSTV = 4'b0001;
`ifdef DEBOUNCE_MULTI_EVT_EN
   localparam bit EVT_ON = 1'b1;
`else
   localparam bit EVT_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] raw_in;
   logic [3:0] evt_clr;
   logic [3:0] db_out, rise_pls, fall_pls, evt_pend;
   logic       irq;

   debounce_multi #(
      .N_CH(4), .CNT_W(4), .DB_CYCLES(DB), .INV_MASK(INV), .RST_VAL(RSTV)
   ) dut (
      .clk(clk), .reset_n(reset_n), .raw_in(raw_in), .db_out(db_out),
      .rise_pls(rise_pls), .fall_pls(fall_pls), .evt_clr(evt_clr),
      .evt_pend(evt_pend), .irq(irq)
   );

   always #5 clk = ~clk;

   // Model: sync2 value per edge, and a level is accepted once the last DB observations all disagree with it.
   logic [3:0] hist [MAXE];
   logic [3:0] s2h  [MAXE];
   int         last_evt [4];
   int         e_idx = 0;
   logic [3:0] m_db, m_rise, m_fall, m_pend;
   logic       m_irq;
   int         n_cmp = 0;
   int         n_err = 0;

   typedef struct {
      logic       rst_n;
      logic [3:0] raw;
      logic [3:0] db;
      logic [3:0] rise;
      logic [3:0] fall;
   } vec_t;
   vec_t tbl [25];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at edge %0d: got %0h, expected %0h", name, e_idx, act, exp);
      end
   endtask

   function automatic void model_edge(input logic r, input logic [3:0] raw, input logic [3:0] clr);
      logic [3:0] p_r, p_f;
      logic       ok;
      p_r = m_rise;
      p_f = m_fall;
      if (!r) begin
         hist[e_idx] = RSTV;
         s2h[e_idx]  = RSTV;
         m_db   = RSTV;
         m_rise = '0;
         m_fall = '0;
         m_pend = '0;
         m_irq  = 1'b0;
         for (int i = 0; i < 4; i++) last_evt[i] = e_idx;
      end else begin
         hist[e_idx] = raw ^ INV;
         s2h[e_idx]  = (e_idx > 0) ? hist[e_idx-1] : RSTV;
         m_rise = '0;
         m_fall = '0;
         for (int i = 0; i < 4; i++) begin
            if (e_idx - last_evt[i] >= int'(DB)) begin
               ok = 1'b1;
               for (int k = e_idx - int'(DB) + 1; k <= e_idx; k++)
                  if (s2h[k-1][i] == m_db[i]) ok = 1'b0;
               if (ok) begin
                  m_db[i]     = ~m_db[i];
                  m_rise[i]   = m_db[i];
                  m_fall[i]   = ~m_db[i];
                  last_evt[i] = e_idx;
               end
            end
         end
         m_pend = EVT_ON ? ((m_pend & ~clr) | p_r | p_f) : 4'b0000;
         m_irq  = |m_pend;
      end
      e_idx++;
   endfunction

   task automatic step(input logic r, input logic [3:0] raw, input logic [3:0] clr);
      if (e_idx >= int'(MAXE) - 1) begin
         $display("FAIL edge_budget: got %0d edges, limit %0d", e_idx, MAXE);
         $fatal(1);
      end
      reset_n = r;
      raw_in  = raw;
      evt_clr = clr;
      @(posedge clk);
      model_edge(r, raw, clr);
      #1;
      chk("db_out",   32'(db_out),   32'(m_db));
      chk("rise_pls", 32'(rise_pls), 32'(m_rise));
      chk("fall_pls", 32'(fall_pls), 32'(m_fall));
      chk("evt_pend", 32'(evt_pend), 32'(m_pend));
      chk("irq",      32'(irq),      32'(m_irq));
   endtask

   initial begin
      logic [3:0] cur, clr;
      logic       seen, found, r;
      int         at, nr;

      reset_n = 1'b0;
      raw_in  = '0;
      evt_clr = '0;
      m_db = RSTV; m_rise = '0; m_fall = '0; m_pend = '0; m_irq = 1'b0;
      for (int i = 0; i < 4; i++) last_evt[i] = 0;

      // Reset rows, then ch0 falls from its reset value of 1 and rises again, 9 edges after each change.
      tbl[0] = '{1'b0, 4'b1111, 4'b0001, 4'b0000, 4'b0000};
      tbl[1] = '{1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
      tbl[2] = '{1'b0, 4'b1010, 4'b0001, 4'b0000, 4'b0000};
      for (int j = 0; j <= 10; j++) begin
         tbl[3+j]  = '{1'b1, 4'b1000, (j >= 9) ? 4'b0000 : 4'b0001, 4'b0000,
                       (j == 9) ? 4'b0001 : 4'b0000};
         tbl[14+j] = '{1'b1, 4'b1001, (j >= 9) ? 4'b0001 : 4'b0000,
                       (j == 9) ? 4'b0001 : 4'b0000, 4'b0000};
      end
      for (int t = 0; t < 25; t++) begin
         step(tbl[t].rst_n, tbl[t].raw, 4'b0000);
         chk("tbl_db",   32'(db_out),   32'(tbl[t].db));
         chk("tbl_rise", 32'(rise_pls), 32'(tbl[t].rise));
         chk("tbl_fall", 32'(fall_pls), 32'(tbl[t].fall));
      end
      chk("tbl_irq", 32'(irq), 32'(EVT_ON));
      cur = 4'b1001;

      // Glitch of 7 cycles on ch1 is rejected; a held level is accepted at edge 9.
      seen = 1'b0;
      cur[1] = 1'b1;
      for (int j = 0; j < 7; j++) begin step(1'b1, cur, 4'b0000); seen |= rise_pls[1]; end
      cur[1] = 1'b0;
      for (int j = 0; j < 12; j++) begin step(1'b1, cur, 4'b0000); seen |= rise_pls[1]; end
      chk("glitch_db", 32'(db_out[1]), 32'(0));
      chk("glitch_pulse", 32'(seen), 32'(0));
      cur[1] = 1'b1; at = -1; nr = 0;
      for (int j = 0; j < 20; j++) begin
         step(1'b1, cur, 4'b0000);
         if (db_out[1] === 1'b1 && at < 0) at = j;
         nr += int'(rise_pls[1]);
      end
      chk("glitch_latency", 32'(at), 32'(9));
      chk("glitch_rises", 32'(nr), 32'(1));

      // Bounce on ch2 every 3 cycles, then settle high: one rise, 9 edges after the last transition.
      nr = 0; at = -1;
      for (int j = 0; j < 30; j++) begin
         cur[2] = ((j / 3) % 2 == 0);
         step(1'b1, cur, 4'b0000);
         nr += int'(rise_pls[2]);
      end
      cur[2] = 1'b1;
      for (int j = 0; j < 20; j++) begin
         step(1'b1, cur, 4'b0000);
         if (rise_pls[2] === 1'b1 && at < 0) at = j;
         nr += int'(rise_pls[2]);
      end
      chk("bounce_latency", 32'(at), 32'(9));
      chk("bounce_rises", 32'(nr), 32'(1));
      chk("bounce_db", 32'(db_out[2]), 32'(1));

      // Inverted ch3 counting, interrupted by reset, restarts from zero.
      cur[3] = 1'b0;
      for (int j = 0; j < 5; j++) step(1'b1, cur, 4'b0000);
      step(1'b0, cur, 4'b0000);
      chk("midrst_db", 32'(db_out), 32'(RSTV));
      chk("midrst_pls", 32'({rise_pls, fall_pls}), 32'(0));
      at = -1;
      for (int j = 0; j < 15; j++) begin
         step(1'b1, cur, 4'b0000);
         if (db_out[3] === 1'b1 && at < 0) at = j;
      end
      chk("inv_latency", 32'(at), 32'(9));

      // Event flags: fall sets, set beats same-cycle clear, clear alone drops irq.
      step(1'b1, cur, 4'b1111);
      step(1'b1, cur, 4'b0000);
      cur[0] = 1'b0; found = 1'b0;
      for (int j = 0; j < 20 && !found; j++) begin
         step(1'b1, cur, 4'b0000);
         found = (fall_pls[0] === 1'b1);
      end
      chk("evt_fall_seen", 32'(found), 32'(1));
      step(1'b1, cur, 4'b0000);
      chk("evt_after_fall", 32'(evt_pend), EVT_ON ? 32'(1) : 32'(0));
      chk("irq_after_fall", 32'(irq), 32'(EVT_ON));
      cur[0] = 1'b1; found = 1'b0;
      for (int j = 0; j < 20 && !found; j++) begin
         step(1'b1, cur, 4'b0000);
         found = (rise_pls[0] === 1'b1);
      end
      chk("evt_rise_seen", 32'(found), 32'(1));
      step(1'b1, cur, 4'b0001);
      chk("evt_set_wins", 32'(evt_pend), EVT_ON ? 32'(1) : 32'(0));
      step(1'b1, cur, 4'b0001);
      chk("evt_cleared", 32'(evt_pend), 32'(0));
      chk("irq_cleared", 32'(irq), 32'(0));
      step(1'b1, cur, 4'b0000);

      // Random traffic against the model, with occasional resets.
      for (int n = 0; n < 3000; n++) begin
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 9) == 0) cur[b] = ~cur[b];
            clr[b] = ($urandom_range(0, 3) == 0);
         end
         r = ($urandom_range(0, 399) != 0);
         step(r, cur, clr);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
